// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared constants for the UART receive datapath
package uart_rx_pkg;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DATA_WIDTH_DEF    = 8;
    localparam int ERR_CNT_WIDTH_DEF = 8;
endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter
    import uart_rx_pkg::*;
#(
    parameter int WIDTH = ERR_CNT_WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Clear dominates a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/uart_rx_deser_chk.sv
// rtl/uart_rx_deser_chk.sv - UART RX deserializer, frame checks and error counters
module uart_rx_deser_chk
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int ERR_CNT_WIDTH = ERR_CNT_WIDTH_DEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     sampled_bit,
    input  logic                     sample_done,
    input  logic                     strt_chk_en,
    input  logic                     deser_en,
    input  logic                     par_chk_en,
    input  logic                     stp_chk_en,
    input  logic                     PAR_TYP,
    input  logic                     DATA_VALID,
    input  logic                     CNT_CLR,
    output logic                     strt_glitch,
    output logic                     par_err,
    output logic                     stp_err,
    output logic [DATA_WIDTH-1:0]    RX_P_DATA,
    output logic                     RX_VALID,
    output logic [ERR_CNT_WIDTH-1:0] par_err_cnt,
    output logic [ERR_CNT_WIDTH-1:0] stp_err_cnt
);
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  strt_glitch_q, strt_glitch_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  par_exp;
    logic                  par_inc;
    logic                  stp_inc;

    always_comb begin
        shreg_d       = shreg_q;
        strt_glitch_d = strt_glitch_q;
        par_err_d     = par_err_q;
        stp_err_d     = stp_err_q;
        rx_valid_d    = DATA_VALID;
        rx_data_d     = DATA_VALID ? shreg_q : rx_data_q;
        par_exp       = (^shreg_q) ^ (PAR_TYP == PAR_ODD);
        par_inc       = 1'b0;
        stp_inc       = 1'b0;

        // Enables are independent; the start check clears first so a
        // same-cycle parity/stop check still lands its own result.
        if (sample_done) begin
            if (strt_chk_en) begin
                strt_glitch_d = sampled_bit;
                par_err_d     = 1'b0;
                stp_err_d     = 1'b0;
            end
            if (deser_en) begin
                shreg_d = {sampled_bit, shreg_q[DATA_WIDTH-1:1]};
            end
            if (par_chk_en) begin
                par_err_d = (sampled_bit != par_exp);
                par_inc   = (sampled_bit != par_exp);
            end
            if (stp_chk_en) begin
                stp_err_d = ~sampled_bit;
                stp_inc   = ~sampled_bit;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg_q       <= '0;
            rx_data_q     <= '0;
            strt_glitch_q <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
            rx_valid_q    <= 1'b0;
        end else begin
            shreg_q       <= shreg_d;
            rx_data_q     <= rx_data_d;
            strt_glitch_q <= strt_glitch_d;
            par_err_q     <= par_err_d;
            stp_err_q     <= stp_err_d;
            rx_valid_q    <= rx_valid_d;
        end
    end

    sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_par_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (par_inc),
        .clr (CNT_CLR),
        .cnt (par_err_cnt)
    );

    sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_stp_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (stp_inc),
        .clr (CNT_CLR),
        .cnt (stp_err_cnt)
    );

    assign strt_glitch = strt_glitch_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;
    assign RX_P_DATA   = rx_data_q;
    assign RX_VALID    = rx_valid_q;
endmodule

// File: tb/tb_uart_rx_deser_chk.sv
// tb/tb_uart_rx_deser_chk.sv - self-checking bench for uart_rx_deser_chk
module tb_uart_rx_deser_chk;
    logic       CLK = 1'b0;
    logic       RST;
    logic       sampled_bit, sample_done, strt_chk_en, deser_en;
    logic       par_chk_en, stp_chk_en, PAR_TYP, DATA_VALID, CNT_CLR;
    logic       strt_glitch, par_err, stp_err, RX_VALID;
    logic [7:0] RX_P_DATA, par_err_cnt, stp_err_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         hist[$];
    logic       m_glitch, m_par, m_stp, m_rxvalid;
    logic [7:0] m_rxdata;
    int         m_pcnt, m_scnt;

    uart_rx_deser_chk dut (
        .CLK         (CLK),
        .RST         (RST),
        .sampled_bit (sampled_bit),
        .sample_done (sample_done),
        .strt_chk_en (strt_chk_en),
        .deser_en    (deser_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .PAR_TYP     (PAR_TYP),
        .DATA_VALID  (DATA_VALID),
        .CNT_CLR     (CNT_CLR),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .RX_P_DATA   (RX_P_DATA),
        .RX_VALID    (RX_VALID),
        .par_err_cnt (par_err_cnt),
        .stp_err_cnt (stp_err_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_word();
        logic [7:0] w;
        for (int i = 0; i < 8; i++) w[i] = hist[i];
        return w;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 8; i++) hist.push_back(1'b0);
        m_glitch = 0; m_par = 0; m_stp = 0; m_rxvalid = 0;
        m_rxdata = 8'h00; m_pcnt = 0; m_scnt = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".strt_glitch"}, {31'd0, strt_glitch}, {31'd0, m_glitch});
        chk({tag, ".par_err"}, {31'd0, par_err}, {31'd0, m_par});
        chk({tag, ".stp_err"}, {31'd0, stp_err}, {31'd0, m_stp});
        chk({tag, ".RX_P_DATA"}, {24'd0, RX_P_DATA}, {24'd0, m_rxdata});
        chk({tag, ".RX_VALID"}, {31'd0, RX_VALID}, {31'd0, m_rxvalid});
        chk({tag, ".par_err_cnt"}, {24'd0, par_err_cnt}, m_pcnt);
        chk({tag, ".stp_err_cnt"}, {24'd0, stp_err_cnt}, m_scnt);
    endtask

    // One clock cycle: drive, advance, update model, compare everything.
    task automatic step(input logic st, input logic de, input logic pa, input logic sp,
                        input logic b, input logic sd, input logic dv, input logic clr,
                        input string tag);
        logic [7:0] w;
        logic       pinc, sinc;
        strt_chk_en = st; deser_en = de; par_chk_en = pa; stp_chk_en = sp;
        sampled_bit = b; sample_done = sd; DATA_VALID = dv; CNT_CLR = clr;
        @(posedge CLK);
        w = model_word();
        pinc = 0; sinc = 0;
        m_rxvalid = dv;
        if (dv) m_rxdata = w;
        if (sd) begin
            if (st) begin m_glitch = b; m_par = 0; m_stp = 0; end
            if (de) begin hist.push_back(b); void'(hist.pop_front()); end
            if (pa) begin
                m_par = (b != ((($countones(w) % 2) == 1) ^ PAR_TYP));
                pinc = m_par;
            end
            if (sp) begin m_stp = ~b; sinc = ~b; end
        end
        if (clr) begin m_pcnt = 0; m_scnt = 0; end
        else begin
            if (pinc && m_pcnt < 255) m_pcnt++;
            if (sinc && m_scnt < 255) m_scnt++;
        end
        #1;
        check_all(tag);
    endtask

    task automatic frame(input logic [7:0] d, input logic pt, input logic pflip,
                         input logic stopb, input logic startb, input string tag);
        PAR_TYP = pt;
        step(1, 0, 0, 0, startb, 1, 0, 0, {tag, ".start"});
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, d[i], 1, 0, 0, {tag, ".data"});
        step(0, 0, 1, 0, (^d) ^ pt ^ pflip, 1, 0, 0, {tag, ".parity"});
        step(0, 0, 0, 1, stopb, 1, 0, 0, {tag, ".stop"});
        step(0, 0, 0, 0, 0, 0, 1, 0, {tag, ".accept"});
        step(0, 0, 0, 0, 0, 0, 0, 0, {tag, ".idle"});
    endtask

    initial begin
        RST = 1'b0;
        {sampled_bit, sample_done, strt_chk_en, deser_en} = '0;
        {par_chk_en, stp_chk_en, PAR_TYP, DATA_VALID, CNT_CLR} = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        RST = 1'b1;

        // Good even-parity frame with 0xA5
        frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, "good_even");
        chk("good_even.data_const", {24'd0, RX_P_DATA}, 32'hA5);

        // Bad parity, then next start clears the flag but not the count
        frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, "bad_par");
        chk("bad_par.flag_const", {31'd0, par_err}, 32'd1);
        chk("bad_par.cnt_const", {24'd0, par_err_cnt}, 32'd1);
        step(1, 0, 0, 0, 0, 1, 0, 0, "bad_par.clear");
        chk("bad_par.cleared_const", {31'd0, par_err}, 32'd0);

        // Odd parity with 0x01
        frame(8'h01, 1'b1, 1'b0, 1'b1, 1'b0, "odd_good");
        chk("odd_good.par_const", {31'd0, par_err}, 32'd0);
        frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b0, "odd_bad");
        chk("odd_bad.par_const", {31'd0, par_err}, 32'd1);

        // Framing error and start glitch
        frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, "frame_err");
        chk("frame_err.stp_const", {31'd0, stp_err}, 32'd1);
        chk("frame_err.glitch_const", {31'd0, strt_glitch}, 32'd1);

        // Enables held without sample_done: nothing changes
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, i[0], 0, 0, 0, "no_strobe");

        // DATA_VALID held for three cycles gives three pulses
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1, 0, "dv_hold");
        step(0, 0, 0, 0, 0, 0, 0, 0, "dv_hold.end");

        // Randomized frames
        for (int n = 0; n < 25; n++) begin
            frame(8'($urandom), 1'($urandom), ($urandom % 4) == 0,
                  ($urandom % 4) != 0, ($urandom % 8) == 0, "rand");
        end

        // Saturation of the stop error counter
        for (int i = 0; i < 300; i++) step(0, 0, 0, 1, 0, 1, 0, 0, "sat");
        chk("sat.cnt_const", {24'd0, stp_err_cnt}, 32'd255);

        // Clear beats a same-cycle increment
        step(0, 0, 1, 1, ~((^RX_P_DATA) ^ PAR_TYP), 1, 0, 1, "clr_inc");
        chk("clr_inc.stp_cnt_const", {24'd0, stp_err_cnt}, 32'd0);

        // Asynchronous reset after four data bits
        PAR_TYP = 1'b0;
        step(1, 0, 0, 0, 0, 1, 0, 0, "mid.start");
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1'b1, 1, 0, 0, "mid.data");
        #2 RST = 1'b0;
        model_reset();
        #1;
        check_all("mid.reset");
        @(negedge CLK);
        RST = 1'b1;
        frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, "after_reset");
        chk("after_reset.data_const", {24'd0, RX_P_DATA}, 32'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_deser_chk.md
# uart_rx_deser_chk

Datapath companion of the UART-RX control FSM. It consumes the FSM's enable strobes and the sampler's per-bit decisions. It shifts data bits into a parallel word and evaluates the start, parity and stop bits. It returns the registered `strt_glitch`, `par_err` and `stp_err` flags to the FSM, and latches the received byte on `DATA_VALID`. It also keeps saturating error counters for the register file.

## Interface

Parameters:
- `DATA_WIDTH`, 8: data bits per frame.
- `ERR_CNT_WIDTH`, 8: width of each saturating error counter.

Ports (clock and reset first):
- `CLK`  in  1  receiver oversampling clock.
- `RST`  in  1  reset, asynchronous, active-low.
- `sampled_bit`  in  1  majority-voted bit value from the data sampler.
- `sample_done`  in  1  one-cycle strobe; `sampled_bit` is final this cycle.
- `strt_chk_en`  in  1  FSM: current bit is the start bit.
- `deser_en`  in  1  FSM: current bit is a data bit.
- `par_chk_en`  in  1  FSM: current bit is the parity bit.
- `stp_chk_en`  in  1  FSM: current bit is the stop bit.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity.
- `DATA_VALID`  in  1  FSM: frame accepted.
- `CNT_CLR`  in  1  synchronous clear of both error counters.
- `strt_glitch`  out  1  start bit sampled high.
- `par_err`  out  1  parity mismatch.
- `stp_err`  out  1  stop bit sampled low.
- `RX_P_DATA`  out  `DATA_WIDTH`  last accepted byte.
- `RX_VALID`  out  1  one-cycle pulse, `RX_P_DATA` updated.
- `par_err_cnt`  out  `ERR_CNT_WIDTH`  parity error count.
- `stp_err_cnt`  out  `ERR_CNT_WIDTH`  stop/framing error count.

## Operation

Each rule below acts only in a cycle where `sample_done`=1:

- **Start bit** (`strt_chk_en`=1):
  - `strt_glitch` <= `sampled_bit`.
  - `par_err` <= 0 and `stp_err` <= 0, so each frame starts clean.
  - The shift register is not cleared.
- **Data bit** (`deser_en`=1): shift the register right, LSB first. New value is {`sampled_bit`, shreg[`DATA_WIDTH`-1:1]}.
- **Parity bit** (`par_chk_en`=1):
  - Expected parity = (^shreg) ^ `PAR_TYP`, using `PAR_TYP` as sampled in this cycle.
  - `par_err` <= (`sampled_bit` != expected).
- **Stop bit** (`stp_chk_en`=1): `stp_err` <= ~`sampled_bit`.

General rules:
- Enables are independent. If several are high together, each acts and none has priority; the FSM guarantees exclusivity.
- If `sample_done`=0, all flags and the shift register hold.
- Flags hold until overwritten by their own check or cleared by the start check.
- **Accept:** `DATA_VALID`=1 gives `RX_P_DATA` <= shreg and `RX_VALID` <= 1 on the next edge. `RX_VALID` is 0 in every other cycle.
  - `DATA_VALID` held high for N cycles gives N pulses with the same data.
- **Counters:**
  - An increment event is the cycle a parity or stop check writes 1 into its flag.
  - Counters saturate at 2^`ERR_CNT_WIDTH`-1.
  - `CNT_CLR` wins over a simultaneous increment: the counter goes to 0.
- **Reset:** every output and internal register is 0, including shreg, all flags, `RX_P_DATA`, `RX_VALID` and both counters.
  - Reset mid-frame discards the partial word.

## Timing

- Every flag, shreg and counter update lands on the clock edge ending the `sample_done` cycle. They are visible in the next cycle.
  - The FSM samples the flags no earlier than one cycle after the strobe.
- Latency from `DATA_VALID` high to `RX_P_DATA`/`RX_VALID` visible: 1 cycle.
- Counter latency: 1 cycle after the `sample_done` cycle that sets its flag.
- No combinational path from any input to any output; all outputs are registered.

## Structure

- Shared package `uart_rx_pkg`:
  - `PAR_EVEN`=1'b0 and `PAR_ODD`=1'b1.
  - Default `DATA_WIDTH` and `ERR_CNT_WIDTH` constants.
- One sub-module `sat_counter`, parameterised by width, with inputs `inc` and `clr`. It is instantiated twice, once per error counter.

## Test plan

- **Good even-parity frame:** `PAR_TYP`=0; start 0, data 0xA5 LSB first (1,0,1,0,0,1,0,1), parity 0, stop 1, then `DATA_VALID` for one cycle.
  - Required: `par_err`=0, `stp_err`=0, `strt_glitch`=0.
  - `RX_P_DATA`=0xA5 with a single `RX_VALID` pulse 1 cycle after `DATA_VALID`.
- **Bad parity:** same frame with parity bit 1.
  - Required: `par_err`=1 one cycle after the parity strobe, `par_err_cnt`=1.
  - The next start strobe clears `par_err` to 0; `par_err_cnt` stays 1.
- **Odd parity:** `PAR_TYP`=1, data 0x01, parity 0 → `par_err`=0. Parity 1 → `par_err`=1.
- **Framing and glitch:**
  - Stop bit sampled 0 → `stp_err`=1, `stp_err_cnt` increments.
  - Start bit sampled 1 → `strt_glitch`=1.
  - Enables held with `sample_done`=0 → no state changes.
- **Saturation and clear:**
  - Force 300 stop errors → `stp_err_cnt`=255.
  - `CNT_CLR` in the same cycle as an increment → 0.
- **Reset mid-frame:** deassert `RST` after 4 data bits.
  - Required: every output is 0 immediately (asynchronous reset).
  - A following good frame with data 0x3C yields `RX_P_DATA`=0x3C.
